mod_counter: RTL and testbench
==============================

Name: mod_counter

Overview:
Parametrised modulo-N up/down counter that replaces the fixed 6-bit seconds counter in the digital clock datapath.
- One instance per time field: seconds/minutes (mod 60), hours (mod 24 or 12), day (mod 31), month (mod 12).
- Cascades through a same-cycle carry-out.
- Loads a preset from the shared databus.
- Holds a per-field compare value for alarm/timer matching.

Parameters:
WIDTH, 6, bit width of the count, din and compare registers.
MODULUS, 60, count range is 0..MODULUS-1; elaboration error unless 2 <= MODULUS <= 2**WIDTH.
RESET_VAL, 0, count value after reset; elaboration error unless RESET_VAL < MODULUS.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  count enable; counts one step per clock while high.
up  input  1  direction: 1 = increment, 0 = decrement.
clear  input  1  synchronous clear of the count to 0.
load  input  1  synchronous load of the count from din.
cmp_load  input  1  synchronous load of the compare register from din.
din  input  WIDTH  databus value used by load and cmp_load.
q  output  WIDTH  current count (registered).
co  output  1  carry/borrow out (combinational), for the enable of the next stage.
match  output  1  registered one-cycle pulse when q becomes equal to the compare value.
load_err  output  1  registered one-cycle pulse when load or cmp_load is rejected.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - q = RESET_VAL, compare register = MODULUS-1.
  - match = 0, load_err = 0.
  - Release takes effect at the next clk edge.
- Count update priority per clock edge: clear > load > en > hold.
  - clear: q <= 0.
  - load with din < MODULUS: q <= din.
  - load with din >= MODULUS: q holds; load_err pulses.
  - en & up: q <= (q == MODULUS-1) ? 0 : q+1.
  - en & ~up: q <= (q == 0) ? MODULUS-1 : q-1.
  - Otherwise q holds.
- co = en & ~clear & ~load & (up ? q == MODULUS-1 : q == 0).
  - Purely combinational so a chain of instances advances in the same edge.
  - No registered latency on co.
- Compare register:
  - cmp_load with din < MODULUS loads it; din >= MODULUS leaves it unchanged and pulses load_err.
  - cmp_load is independent of the count priority and may coincide with clear/load/en.
- load_err:
  - High for exactly one cycle after any edge on which load or cmp_load was rejected.
  - Simultaneous rejections still produce one pulse.
- match:
  - Asserted for the cycle after an edge where q_next == cmp_q_old and q_next != q, whatever the cause (clear, load or count).
  - A q that stays equal to the compare value produces no repeated pulse.
  - Loading the compare register equal to the current q produces no pulse.
- Arithmetic: all comparisons and wraps are done at WIDTH bits. q never leaves 0..MODULUS-1 under any input sequence.
- en, clear and load all low: q, co, and the compare register are static; match and load_err are 0.

Decomposition:
- Shared package clock_pkg holds per-field constants, instantiated with these parameters:
  - SEC_W=6, MOD_SEC=60
  - MIN_W=6, MOD_MIN=60
  - HR_W=5, MOD_HR24=24, MOD_HR12=12
  - DAY_W=5, MOD_DAY=31
  - MON_W=4, MOD_MON=12
- No sub-module is needed: next-state logic, the compare register, match detection and load validation all sit in mod_counter.
- Field chaining (seconds co -> minutes en) belongs to the enclosing clock top, not to this block.

Test Plan:
- Default params; reset, en=1, up=1 for 61 clocks.
  - q runs 0..59, then 0, then 1.
  - co high only in the cycles q==59.
  - Reset mid-count (q=37) forces q=0 immediately, without waiting for a clock edge.
- MODULUS=24, WIDTH=5, up=0, starting from q=0.
  - First edge gives q=23 with co high in the cycle before it.
  - Second edge gives q=22.
- load din=45.
  - Result: q=45, load_err=0.
- load din=60.
  - q stays 45; load_err high exactly one cycle.
- Simultaneous clear=1, load=1 (din=10), en=1.
  - q=0 and co=0 that cycle (clear wins).
- cmp_load din=5, then count up from q=3.
  - match pulses exactly once, the cycle after q reaches 5; no pulse while q holds at 5 with en=0.
- cmp_load din=5 while q==5.
  - No match pulse.
- Two chained instances: seconds (mod 60) with co driving the en of minutes (mod 60), seconds preloaded to 58, minutes to 59.
  - After 2 clocks both read 0 on the same edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Field widths and moduli for the digital clock datapath.
// Every time-field counter instance takes its parameters from here.
package clock_pkg;

  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MOD_SEC  = 60;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned MOD_MIN  = 60;
  localparam int unsigned HR_W     = 5;
  localparam int unsigned MOD_HR24 = 24;
  localparam int unsigned MOD_HR12 = 12;
  localparam int unsigned DAY_W    = 5;
  localparam int unsigned MOD_DAY  = 31;
  localparam int unsigned MON_W    = 4;
  localparam int unsigned MOD_MON  = 12;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up/down counter for one time field: preset load, compare match,
// and a combinational carry/borrow so cascaded fields advance on the same edge.
module mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned WIDTH     = SEC_W,
  parameter int unsigned MODULUS   = MOD_SEC,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic             cmp_load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             match,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("mod_counter: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_cmp;
  logic             r_match;
  logic             r_load_err;

  logic [WIDTH-1:0] w_q_next;
  logic             w_din_ok;
  logic             w_at_end;
  logic             w_reject;

  assign w_din_ok = ({1'b0, din} < MOD_X);
  assign w_at_end = up ? (r_q == MAX_Q) : (r_q == '0);

  always_comb begin
    w_q_next = r_q;
    if (clear) begin
      w_q_next = '0;
    end else if (load) begin
      if (w_din_ok) w_q_next = din;
    end else if (en) begin
      if (up) w_q_next = (r_q == MAX_Q) ? '0 : r_q + WIDTH'(1);
      else    w_q_next = (r_q == '0) ? MAX_Q : r_q - WIDTH'(1);
    end
  end

  // A load masked by clear is never evaluated, so it cannot be rejected.
  assign w_reject = (load & ~clear & ~w_din_ok) | (cmp_load & ~w_din_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= RST_Q;
      r_cmp      <= MAX_Q;
      r_match    <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_q_next;
      r_match    <= (w_q_next == r_cmp) && (w_q_next != r_q);
      r_load_err <= w_reject;
      if (cmp_load && w_din_ok) r_cmp <= din;
    end
  end

  assign q        = r_q;
  assign co       = en & ~clear & ~load & w_at_end;
  assign match    = r_match;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: count sweep, async reset, vector table,
// mod-24 down wrap, and a two-stage seconds/minutes cascade.
module tb_mod_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Default instance (mod 60)
  logic       en0 = 0, up0 = 1, clr0 = 0, ld0 = 0, cl0 = 0;
  logic [5:0] din0 = '0, q0;
  logic       co0, m0, e0;
  mod_counter u0 (.clk(clk), .rst_n(rst_n), .en(en0), .up(up0), .clear(clr0),
                  .load(ld0), .cmp_load(cl0), .din(din0), .q(q0), .co(co0),
                  .match(m0), .load_err(e0));

  // Hours instance (mod 24, 5 bits)
  logic       en1 = 0, up1 = 1, clr1 = 0, ld1 = 0, cl1 = 0;
  logic [4:0] din1 = '0, q1;
  logic       co1, m1, e1;
  mod_counter #(.WIDTH(5), .MODULUS(24)) u1 (.clk(clk), .rst_n(rst_n), .en(en1), .up(up1),
                  .clear(clr1), .load(ld1), .cmp_load(cl1), .din(din1), .q(q1), .co(co1),
                  .match(m1), .load_err(e1));

  // Seconds -> minutes cascade
  logic       en_s = 0, ld_s = 0, ld_mn = 0;
  logic [5:0] din_s = '0, din_mn = '0, q_s, q_mn;
  logic       co_s, m_s, e_s, co_mn, m_mn, e_mn;
  mod_counter u_sec (.clk(clk), .rst_n(rst_n), .en(en_s), .up(1'b1), .clear(1'b0),
                  .load(ld_s), .cmp_load(1'b0), .din(din_s), .q(q_s), .co(co_s),
                  .match(m_s), .load_err(e_s));
  mod_counter u_min (.clk(clk), .rst_n(rst_n), .en(co_s), .up(1'b1), .clear(1'b0),
                  .load(ld_mn), .cmp_load(1'b0), .din(din_mn), .q(q_mn), .co(co_mn),
                  .match(m_mn), .load_err(e_mn));

  typedef struct {
    logic       clear, load, en, up, cmp_load;
    logic [5:0] din;
    logic       exp_co;
    logic [5:0] exp_q;
    logic       exp_match, exp_err;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           clr ld en up cl din co  q  m  e
    vecs[0]  = '{0, 1, 0, 1, 0, 45, 0, 45, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 60, 0, 45, 0, 1};
    vecs[2]  = '{0, 0, 0, 1, 0,  0, 0, 45, 0, 0};
    vecs[3]  = '{1, 1, 1, 1, 0, 10, 0,  0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 1,  5, 0,  0, 0, 0};
    vecs[5]  = '{0, 1, 0, 1, 0,  3, 0,  3, 0, 0};
    vecs[6]  = '{0, 0, 1, 1, 0,  0, 0,  4, 0, 0};
    vecs[7]  = '{0, 0, 1, 1, 0,  0, 0,  5, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 0,  0, 0,  5, 0, 0};
    vecs[9]  = '{0, 0, 0, 1, 0,  0, 0,  5, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 1,  5, 0,  5, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 1, 63, 0,  5, 0, 1};
    vecs[12] = '{0, 0, 1, 1, 0,  0, 0,  6, 0, 0};
    vecs[13] = '{0, 0, 1, 0, 0,  0, 0,  5, 1, 0};
    vecs[14] = '{0, 1, 0, 1, 1, 59, 0, 59, 0, 0};
    vecs[15] = '{0, 0, 1, 1, 0,  0, 1,  0, 0, 0};
    vecs[16] = '{0, 0, 1, 0, 0,  0, 1, 59, 1, 0};
    vecs[17] = '{0, 1, 0, 1, 1, 60, 0, 59, 0, 1};
    vecs[18] = '{0, 0, 0, 1, 0,  0, 0, 59, 0, 0};
    vecs[19] = '{1, 0, 0, 1, 0,  0, 0,  0, 0, 0};

    #12;
    chk("reset_q", 32'(q0), 0);
    chk("reset_match", 32'(m0), 0);
    chk("reset_err", 32'(e0), 0);
    rst_n = 1'b1;
    #10;
    chk("idle_q", 32'(q0), 0);

    begin
      int mq = 0;
      en0 = 1; up0 = 1;
      #1;
      for (int i = 0; i < 61; i++) begin
        chk("sweep_co", 32'(co0), 32'(mq == 59));
        edge1();
        mq = (mq + 1) % 60;
        chk("sweep_q", 32'(q0), 32'(mq));
        chk("sweep_match", 32'(m0), 32'(mq == 59));
      end
      chk("sweep_end_q", 32'(q0), 1);
      for (int i = 0; i < 36; i++) edge1();
      chk("pre_reset_q", 32'(q0), 37);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_q", 32'(q0), 0);
      en0 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      edge1();
      chk("post_reset_q", 32'(q0), 0);
    end

    for (int i = 0; i < 20; i++) begin
      clr0 = vecs[i].clear; ld0 = vecs[i].load; en0 = vecs[i].en;
      up0 = vecs[i].up; cl0 = vecs[i].cmp_load; din0 = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_co", i), 32'(co0), 32'(vecs[i].exp_co));
      edge1();
      chk($sformatf("vec%0d_q", i), 32'(q0), 32'(vecs[i].exp_q));
      chk($sformatf("vec%0d_match", i), 32'(m0), 32'(vecs[i].exp_match));
      chk($sformatf("vec%0d_err", i), 32'(e0), 32'(vecs[i].exp_err));
    end
    clr0 = 0; ld0 = 0; en0 = 0; cl0 = 0;

    chk("hr_start_q", 32'(q1), 0);
    en1 = 1; up1 = 0;
    #1 chk("hr_borrow_co", 32'(co1), 1);
    edge1();
    chk("hr_wrap_q", 32'(q1), 23);
    chk("hr_co_after_wrap", 32'(co1), 0);
    edge1();
    chk("hr_dec_q", 32'(q1), 22);
    en1 = 0;

    ld_s = 1; din_s = 58; ld_mn = 1; din_mn = 59;
    edge1();
    ld_s = 0; ld_mn = 0;
    chk("chain_sec_pre", 32'(q_s), 58);
    chk("chain_min_pre", 32'(q_mn), 59);
    en_s = 1;
    #1 chk("chain_co_s0", 32'(co_s), 0);
    edge1();
    chk("chain_sec1", 32'(q_s), 59);
    chk("chain_min1", 32'(q_mn), 59);
    chk("chain_co_s1", 32'(co_s), 1);
    chk("chain_co_mn1", 32'(co_mn), 1);
    edge1();
    chk("chain_sec2", 32'(q_s), 0);
    chk("chain_min2", 32'(q_mn), 0);
    en_s = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
